// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcode encodings, datapath defaults shared with the alu, and the
//            rule that decides whether an opcode writes its destination.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH        = 8;
    localparam int ALU_OPCODE_WIDTH = 3;

    localparam logic [ALU_OPCODE_WIDTH-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OPCODE_WIDTH-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OPCODE_WIDTH-1:0] OP_AND = 3'b010;
    localparam logic [ALU_OPCODE_WIDTH-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_OPCODE_WIDTH-1:0] OP_XOR = 3'b100;
    localparam logic [ALU_OPCODE_WIDTH-1:0] OP_CMP = 3'b101;
    localparam logic [ALU_OPCODE_WIDTH-1:0] OP_SHL = 3'b110;
    localparam logic [ALU_OPCODE_WIDTH-1:0] OP_SHR = 3'b111;

    // CMP only updates the compare flags; every other opcode writes rd.
    function automatic logic writes_rd(input logic [ALU_OPCODE_WIDTH-1:0] opcode);
        return (opcode != OP_CMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Purpose  : NUM_REGS x WIDTH register file, async active-low reset,
//            three combinational read ports (rs1, rs2, debug) and one
//            synchronous write port. Reads always return the pre-write value.
// Revision : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH    = ALU_WIDTH,
    parameter int NUM_REGS = 4,
    parameter int RA       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [RA-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [RA-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic [RA-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data2,
    input  logic [RA-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    // Next-state: only the addressed entry changes on a write.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Storage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd_data1 = regs_q[rd_addr1];
    assign rd_data2 = regs_q[rd_addr2];
    assign dbg_data = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Execute stage of the 8-bit uC. Accepts decoded instructions on a
//            valid/ready handshake, reads operands from alu_regfile into the
//            EX register that drives the external alu, and retires the alu
//            result into the register file and status flags one cycle later.
// Config   : ALU_EXEC_FWD_EN - when defined, a RAW hazard on the instruction
//            in EX is resolved by bypassing alu_result (in_ready stays 1);
//            otherwise the incoming instruction is stalled for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH        = ALU_WIDTH,
    parameter int OPCODE_WIDTH = ALU_OPCODE_WIDTH,
    parameter int NUM_REGS     = 4,
    parameter int RA           = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] in_opcode,
    input  logic [RA-1:0]           in_rd,
    input  logic [RA-1:0]           in_rs1,
    input  logic [RA-1:0]           in_rs2,
    input  logic                    in_use_imm,
    input  logic [WIDTH-1:0]        in_imm,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic                    alu_carry,
    input  logic                    alu_a_greater,
    input  logic                    alu_a_equal,
    output logic                    flag_c,
    output logic                    flag_z,
    output logic                    flag_gt,
    output logic                    flag_eq,
    output logic                    ret_valid,
    output logic [RA-1:0]           ret_rd,
    output logic [WIDTH-1:0]        ret_data,
    input  logic [RA-1:0]           dbg_addr,
    output logic [WIDTH-1:0]        dbg_data
);

    // EX register
    logic                    ex_valid_q, ex_valid_d;
    logic [OPCODE_WIDTH-1:0] ex_op_q,    ex_op_d;
    logic [RA-1:0]           ex_rd_q,    ex_rd_d;
    logic [WIDTH-1:0]        ex_a_q,     ex_a_d;
    logic [WIDTH-1:0]        ex_b_q,     ex_b_d;

    // Flags and retire reporting
    logic                    flag_c_q,   flag_c_d;
    logic                    flag_z_q,   flag_z_d;
    logic                    flag_gt_q,  flag_gt_d;
    logic                    flag_eq_q,  flag_eq_d;
    logic                    ret_valid_q, ret_valid_d;
    logic [RA-1:0]           ret_rd_q,   ret_rd_d;
    logic [WIDTH-1:0]        ret_data_q, ret_data_d;

    logic [WIDTH-1:0]        rs1_data, rs2_data;
    logic [WIDTH-1:0]        op_a, op_b;
    logic                    ex_writes;
    logic                    rf_wr_en;
    logic                    hazard_a, hazard_b;
    logic                    accept;

    alu_regfile #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .RA       (RA)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (rf_wr_en),
        .wr_addr  (ex_rd_q),
        .wr_data  (alu_result),
        .rd_addr1 (in_rs1),
        .rd_data1 (rs1_data),
        .rd_addr2 (in_rs2),
        .rd_data2 (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Hazard detection against the instruction currently in EX; a CMP in EX
    // never writes, so it can never be the producer of a hazard.
    always_comb begin
        ex_writes = ex_valid_q && writes_rd(ex_op_q);
        rf_wr_en  = ex_writes;
        hazard_a  = ex_writes && (in_rs1 == ex_rd_q);
        hazard_b  = ex_writes && !in_use_imm && (in_rs2 == ex_rd_q);
    end

`ifdef ALU_EXEC_FWD_EN
    // Bypass: a hazard operand takes the result the alu is producing now.
    always_comb begin
        in_ready = 1'b1;
        op_a     = hazard_a ? alu_result : rs1_data;
        op_b     = hazard_b ? alu_result : rs2_data;
    end
`else
    // Stall: hold off the dependent instruction for the single cycle it takes
    // the producer to retire; the regfile then returns the written value.
    always_comb begin
        in_ready = !(hazard_a || hazard_b);
        op_a     = rs1_data;
        op_b     = rs2_data;
    end
`endif

    // Next-state for EX register, retire reporting and flags.
    always_comb begin
        accept      = in_valid && in_ready;

        ex_valid_d  = accept;
        ex_op_d     = ex_op_q;
        ex_rd_d     = ex_rd_q;
        ex_a_d      = ex_a_q;
        ex_b_d      = ex_b_q;

        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        flag_gt_d   = flag_gt_q;
        flag_eq_d   = flag_eq_q;
        ret_valid_d = 1'b0;
        ret_rd_d    = ret_rd_q;
        ret_data_d  = ret_data_q;

        if (accept) begin
            ex_op_d = in_opcode;
            ex_rd_d = in_rd;
            ex_a_d  = op_a;
            ex_b_d  = in_use_imm ? in_imm : op_b;
        end

        if (ex_valid_q) begin
            if (ex_writes) begin
                flag_z_d    = (alu_result == '0);
                ret_valid_d = 1'b1;
                ret_rd_d    = ex_rd_q;
                ret_data_d  = alu_result;
            end else begin
                flag_gt_d   = alu_a_greater;
                flag_eq_d   = alu_a_equal;
            end
            if (ex_op_q == OP_ADD) begin
                flag_c_d = alu_carry;
            end
        end
    end

    // State registers; reset discards any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_op_q     <= '0;
            ex_rd_q     <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_gt_q   <= 1'b0;
            flag_eq_q   <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_rd_q    <= '0;
            ret_data_q  <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= ex_op_d;
            ex_rd_q     <= ex_rd_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            flag_gt_q   <= flag_gt_d;
            flag_eq_q   <= flag_eq_d;
            ret_valid_q <= ret_valid_d;
            ret_rd_q    <= ret_rd_d;
            ret_data_q  <= ret_data_d;
        end
    end

    assign alu_a      = ex_a_q;
    assign alu_b      = ex_b_q;
    assign alu_opcode = ex_op_q;
    assign flag_c     = flag_c_q;
    assign flag_z     = flag_z_q;
    assign flag_gt    = flag_gt_q;
    assign flag_eq    = flag_eq_q;
    assign ret_valid  = ret_valid_q;
    assign ret_rd     = ret_rd_q;
    assign ret_data   = ret_data_q;

endmodule
`default_nettype wire
